// File: rtl/period_meter_if.sv
// Signal bundle between a period_meter and the logic that starts it and consumes its results.
interface period_meter_if #(
  parameter int CNT_W = 8
);
  logic             sig_in;
  logic             start;
  logic             busy;
  logic             valid;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             overflow;

  modport master (
    output sig_in, start,
    input  busy, valid, period, high_time, overflow
  );

  modport slave (
    input  sig_in, start,
    output busy, valid, period, high_time, overflow
  );
endinterface

// File: rtl/period_meter.sv
// Measures the period and high time of sig_in between two rising edges, in clk cycles.
// Define PERIOD_METER_CONTINUOUS_EN to report every period back-to-back instead of one-shot.
module period_meter #(
  parameter int CNT_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  period_meter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  state_t           state_next;
  logic             sig_d;
  logic             rise;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] high_time_q;
  logic             valid_q;
  logic             overflow_q;

  logic load;
  logic count;
  logic capture;
  logic set_ovf;
  logic clr_ovf;

  assign rise = bus.sig_in & ~sig_d;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latches).
    state_next = state;
    load       = 1'b0;
    count      = 1'b0;
    capture    = 1'b0;
    set_ovf    = 1'b0;
    clr_ovf    = 1'b0;
    unique case (state)
      IDLE: begin
        // A rise coinciding with start only arms; the opening edge must come later.
        if (bus.start) begin
          state_next = ARM;
          clr_ovf    = 1'b1;
        end
      end
      ARM: begin
        if (rise) begin
          state_next = MEASURE;
          load       = 1'b1;
        end
      end
      MEASURE: begin
        if (rise) begin
          capture = 1'b1;
`ifdef PERIOD_METER_CONTINUOUS_EN
          load    = 1'b1;
`else
          state_next = IDLE;
`endif
        end else if (cnt == CNT_MAX) begin
          set_ovf    = 1'b1;
          state_next = IDLE;
        end else begin
          count = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The opening-edge cycle counts as one period cycle and, sig_in being high there, one high cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      sig_d       <= 1'b0;
      cnt         <= '0;
      hcnt        <= '0;
      period_q    <= '0;
      high_time_q <= '0;
      valid_q     <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      sig_d   <= bus.sig_in;
      valid_q <= capture;
      if (load) begin
        cnt  <= CNT_W'(1);
        hcnt <= CNT_W'(1);
      end else if (count) begin
        cnt <= cnt + CNT_W'(1);
        if (bus.sig_in) hcnt <= hcnt + CNT_W'(1);
      end
      if (capture) begin
        period_q    <= cnt;
        high_time_q <= hcnt;
      end
      if (set_ovf)      overflow_q <= 1'b1;
      else if (clr_ovf) overflow_q <= 1'b0;
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.valid     = valid_q;
  assign bus.period    = period_q;
  assign bus.high_time = high_time_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter: an 8-bit instance for the main behaviour and a 4-bit one for overflow.
module tb_period_meter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   ovf_at;
  int   vcount;
  int   busy_low;

  period_meter_if #(.CNT_W(8)) bus ();
  period_meter_if #(.CNT_W(4)) bus4 ();

  period_meter #(.CNT_W(8)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  period_meter #(.CNT_W(4)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic s, input logic st);
    bus.sig_in = s;
    bus.start  = st;
    tick();
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    bus.sig_in   = 1'b0;
    bus.start    = 1'b0;
    bus4.sig_in  = 1'b0;
    bus4.start   = 1'b0;

    // Reset
    step(0, 0);
    step(0, 0);
    rst = 1'b0;
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_valid", 32'(bus.valid), 0);
    check("rst_period", 32'(bus.period), 0);
    check("rst_high", 32'(bus.high_time), 0);
    check("rst_ovf", 32'(bus.overflow), 0);

    // Mod-3 MSB pattern 0,0,1
    step(0, 1);
    check("t1_arm_busy", 32'(bus.busy), 1);
    step(0, 0);
    step(0, 0);
    step(1, 0);
    step(0, 0);
    step(0, 0);
    check("t1_pre_valid", 32'(bus.valid), 0);
    step(1, 0);
    check("t1_valid", 32'(bus.valid), 1);
    check("t1_period", 32'(bus.period), 3);
    check("t1_high", 32'(bus.high_time), 1);
`ifdef PERIOD_METER_CONTINUOUS_EN
    check("t1_busy_cont", 32'(bus.busy), 1);
    step(0, 0);
    check("t1_valid_drop", 32'(bus.valid), 0);
    step(0, 0);
    step(1, 0);
    check("t1_valid2", 32'(bus.valid), 1);
    check("t1_period2", 32'(bus.period), 3);
    rst = 1'b1;
    step(0, 0);
    rst = 1'b0;
`else
    check("t1_busy_done", 32'(bus.busy), 0);
    step(0, 0);
    check("t1_valid_drop", 32'(bus.valid), 0);
    check("t1_idle_busy", 32'(bus.busy), 0);
`endif

    // Divide-by-4 square wave
    step(0, 1);
    step(1, 0);
    step(1, 0);
    step(0, 0);
    step(0, 0);
    step(1, 0);
    check("t2_valid", 32'(bus.valid), 1);
    check("t2_period", 32'(bus.period), 4);
    check("t2_high", 32'(bus.high_time), 2);
    step(1, 0);
    step(0, 0);
    step(0, 0);
    check("t2_gap_valid", 32'(bus.valid), 0);
    step(1, 0);
`ifdef PERIOD_METER_CONTINUOUS_EN
    check("t2_valid2", 32'(bus.valid), 1);
    check("t2_period2", 32'(bus.period), 4);
    check("t2_high2", 32'(bus.high_time), 2);
`else
    check("t2_no_rearm_valid", 32'(bus.valid), 0);
    check("t2_no_rearm_busy", 32'(bus.busy), 0);
    check("t2_hold_period", 32'(bus.period), 4);
    check("t2_hold_high", 32'(bus.high_time), 2);
`endif

    // Overflow on the 4-bit instance: one rise, then low
    bus4.start = 1'b1;
    tick();
    bus4.start = 1'b0;
    check("t3_arm_busy", 32'(bus4.busy), 1);
    bus4.sig_in = 1'b1;
    tick();
    bus4.sig_in = 1'b0;
    ovf_at = 0;
    vcount = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus4.valid) vcount++;
      if (bus4.overflow && ovf_at == 0) ovf_at = i;
    end
    check("t3_ovf_cycle", 32'(ovf_at), 15);
    check("t3_no_valid", 32'(vcount), 0);
    check("t3_ovf", 32'(bus4.overflow), 1);
    check("t3_idle", 32'(bus4.busy), 0);
    check("t3_period", 32'(bus4.period), 0);
    bus4.start = 1'b1;
    tick();
    bus4.start = 1'b0;
    check("t3_ovf_clear", 32'(bus4.overflow), 0);
    check("t3_rearm", 32'(bus4.busy), 1);

    // Constant sig_in keeps ARM, then reset mid-measurement
    step(0, 1);
    busy_low = 0;
    vcount   = 0;
    for (int i = 0; i < 30; i++) begin
      step(0, 0);
      if (!bus.busy) busy_low++;
      if (bus.valid) vcount++;
    end
    check("t4_arm_hold", 32'(busy_low), 0);
    check("t4_arm_novalid", 32'(vcount), 0);
    step(1, 0);
    step(0, 0);
    rst = 1'b1;
    step(0, 0);
    rst = 1'b0;
    check("t4_rst_busy", 32'(bus.busy), 0);
    check("t4_rst_valid", 32'(bus.valid), 0);
    check("t4_rst_period", 32'(bus.period), 0);
    check("t4_rst_high", 32'(bus.high_time), 0);
    check("t4_rst_ovf", 32'(bus.overflow), 0);
    step(0, 0);
    check("t4_rst_novalid", 32'(bus.valid), 0);
    step(0, 1);
    step(1, 0);
    step(0, 0);
    step(0, 0);
    step(0, 0);
    step(0, 0);
    step(1, 0);
    check("t4_valid", 32'(bus.valid), 1);
    check("t4_period", 32'(bus.period), 5);
    check("t4_high", 32'(bus.high_time), 1);
`ifdef PERIOD_METER_CONTINUOUS_EN
    rst = 1'b1;
    step(0, 0);
    rst = 1'b0;
`endif

    // Period-6 signal with start pulses during MEASURE
    step(0, 0);
    step(0, 1);
    step(1, 0);
    step(1, 1);
    check("t5_busy", 32'(bus.busy), 1);
    step(1, 1);
    step(0, 0);
    step(0, 1);
    step(0, 0);
    check("t5_pre_valid", 32'(bus.valid), 0);
    step(1, 0);
    check("t5_valid", 32'(bus.valid), 1);
    check("t5_period", 32'(bus.period), 6);
    check("t5_high", 32'(bus.high_time), 3);
`ifdef PERIOD_METER_CONTINUOUS_EN
    rst = 1'b1;
    step(0, 0);
    rst = 1'b0;
`else
    step(1, 0);
    step(1, 0);
    step(0, 0);
    step(0, 0);
    step(0, 0);
    step(0, 0);
    step(1, 0);
    check("t5_single_valid", 32'(bus.valid), 0);
    check("t5_idle", 32'(bus.busy), 0);
`endif

    // Start coincident with a rise in IDLE: that rise must not open the measurement
    step(0, 0);
    step(1, 1);
    step(1, 0);
    check("t6_armed", 32'(bus.busy), 1);
    step(1, 0);
    step(0, 0);
    step(1, 0);
    check("t6_open_novalid", 32'(bus.valid), 0);
    step(0, 0);
    step(0, 0);
    step(1, 0);
    check("t6_valid", 32'(bus.valid), 1);
    check("t6_period", 32'(bus.period), 3);
    check("t6_high", 32'(bus.high_time), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/period_meter.md
PERIOD_METER -- requirements
Module: period_meter

Interface
REQ-001 CNT_W, 8, width of the period and high-time counters and outputs; legal range 4..16.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 sig_in  input  1  measured signal, synchronous to clk (e.g. an upstream divided-count bit).
REQ-005 start  input  1  one-cycle request to begin a measurement; honoured only in IDLE.
REQ-006 busy  output  1  high in every state except IDLE.
REQ-007 valid  output  1  one-cycle pulse when period/high_time are updated.
REQ-008 period  output  CNT_W  clk cycles between two consecutive sig_in rising edges.
REQ-009 high_time  output  CNT_W  clk cycles sig_in was high within the measured period.
REQ-010 overflow  output  1  sticky flag indicating the counter saturated before the closing edge.

Function
REQ-011 The block SHALL register sig_in into sig_d each cycle; rise = sig_in & ~sig_d.
REQ-012 The FSM SHALL have exactly three states: IDLE, ARM, MEASURE.
REQ-013 IDLE: start=1 -> ARM and clear overflow; otherwise hold.
REQ-014 ARM: rise=1 -> MEASURE with cnt<=1 and hcnt<=1; otherwise hold.
REQ-015 MEASURE without rise: cnt<=cnt+1; hcnt<=hcnt+1 when sig_in=1.
REQ-016 MEASURE with rise: period<=cnt, high_time<=hcnt, valid<=1 for that single update, next state IDLE.
REQ-017 Latency: valid, period and high_time are visible on the clk edge following the cycle in which the closing rise is sampled.
REQ-018 MEASURE with cnt = 2^CNT_W-1 and no rise: overflow<=1, state<=IDLE, no valid pulse, period/high_time unchanged.
REQ-019 start asserted in ARM or MEASURE SHALL be ignored.
REQ-020 start and rise in the same IDLE cycle SHALL only move to ARM; that rise is not used as an opening edge.
REQ-021 period and high_time SHALL hold their last values until the next valid update.
REQ-022 Constant sig_in (no edges) SHALL leave the block in ARM indefinitely; no timeout.
REQ-023 Counter arithmetic SHALL be unsigned CNT_W bits; hcnt never exceeds cnt.

Reset
REQ-024 rst=1 SHALL force IDLE, sig_d=0, cnt=0, hcnt=0, period=0, high_time=0, valid=0, overflow=0, busy=0 on the next clk edge.
REQ-025 rst SHALL take priority over start and rise in every state, including mid-measurement; no valid pulse results.

Configuration
REQ-026 Macro PERIOD_METER_CONTINUOUS_EN SHALL select measurement mode.
REQ-027 Without it: one-shot; each measurement requires a new start (REQ-016 returns to IDLE).
REQ-028 With it: on a closing rise the FSM SHALL stay in MEASURE, reload cnt<=1 and hcnt<=1, and report every subsequent period back-to-back until rst or overflow; start in IDLE still required to arm.
REQ-029 With it: overflow SHALL still return to IDLE and stop continuous operation.

Verification
REQ-030 sig_in = mod-3 counter MSB pattern 0,0,1 repeating, start pulse -> valid once, period=3, high_time=1, busy low after valid.
REQ-031 sig_in = divide-by-4 square wave (2 high, 2 low), start -> period=4, high_time=2; with PERIOD_METER_CONTINUOUS_EN, valid every 4 cycles with same values.
REQ-032 CNT_W=4, sig_in single rise then held low 20 cycles -> overflow=1 after 15 counted cycles, no valid, state IDLE; next start clears overflow.
REQ-033 rst asserted in MEASURE after 2 counted cycles -> all outputs 0 next edge, no valid; later start with period-5 signal -> period=5.
REQ-034 start re-pulsed while in MEASURE of period-6 signal -> ignored, single valid with period=6; start coincident with rise in IDLE -> measurement opens on the following rise.
